// File: rtl/and_ary_pkg.sv
// Shared types and constants for the pairwise AND reduction operand path.
package and_ary_pkg;

    typedef enum logic {FILL, HOLD} ld_state_t;

    localparam logic AND_IDENTITY = 1'b1;

endpackage

// File: rtl/and_ary_operand_loader_if.sv
// Beat-in / word-out handshake bundle between the operand feeder, the loader and the AND tree.
interface and_ary_operand_loader_if #(
    parameter int unsigned N     = 8,
    parameter int unsigned CNT_W = 3
);

    logic             in_valid;
    logic             in_ready;
    logic             in_a;
    logic             in_b;
    logic             in_last;
    logic             out_valid;
    logic             out_ready;
    logic [N-1:0]     a_vec;
    logic [N-1:0]     b_vec;
    logic [CNT_W:0]   word_len;

    // Environment side: produces beats, consumes words.
    modport master (
        output in_valid, in_a, in_b, in_last, out_ready,
        input  in_ready, out_valid, a_vec, b_vec, word_len
    );

    // Loader side.
    modport slave (
        input  in_valid, in_a, in_b, in_last, out_ready,
        output in_ready, out_valid, a_vec, b_vec, word_len
    );

endinterface

// File: rtl/and_ary_lane_reg.sv
// One lane of the operand word: an (a, b) flop pair with load enable and preset to the AND identity.
module and_ary_lane_reg
    import and_ary_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       load,
    input  logic       preset,
    input  logic [1:0] d,
    output logic [1:0] q
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q <= {2{AND_IDENTITY}};
        end else if (preset) begin
            q <= {2{AND_IDENTITY}};
        end else if (load) begin
            q <= d;
        end
    end

endmodule

// File: rtl/and_ary_operand_loader.sv
// Collects (a_i, b_i) beats into N-wide words for the pairwise AND tree; short words
// are padded with the AND identity so the reduction result is unaffected.
module and_ary_operand_loader
    import and_ary_pkg::*;
#(
    parameter int unsigned N     = 8,
    parameter int unsigned CNT_W = 3
) (
    input  logic                  clk,
    input  logic                  rst,
    and_ary_operand_loader_if.slave bus
);

    localparam int unsigned LEN_W = CNT_W + 1;

    ld_state_t          state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [LEN_W-1:0]   word_len_q, word_len_d;
    logic               in_ready_q, in_ready_d;
    logic               out_valid_q, out_valid_d;
    logic               load_c;
    logic               preset_c;
    logic [N-1:0]       a_vec_q;
    logic [N-1:0]       b_vec_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= FILL;
            cnt_q       <= '0;
            word_len_q  <= '0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            word_len_q  <= word_len_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
        end
    end

    // Next state; in_ready/out_valid are precomputed so they leave as plain flops.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        word_len_d  = word_len_q;
        in_ready_d  = in_ready_q;
        out_valid_d = out_valid_q;
        load_c      = 1'b0;
        preset_c    = 1'b0;
        unique case (state_q)
            FILL: begin
                if (bus.in_valid) begin
                    load_c = 1'b1;
                    cnt_d  = cnt_q + CNT_W'(1);
                    if (cnt_q == CNT_W'(N - 1) || bus.in_last) begin
                        state_d     = HOLD;
                        word_len_d  = LEN_W'(cnt_q) + LEN_W'(1);
                        cnt_d       = '0;
                        in_ready_d  = 1'b0;
                        out_valid_d = 1'b1;
                    end
                end
            end
            HOLD: begin
                if (bus.out_ready) begin
                    state_d     = FILL;
                    preset_c    = 1'b1;
                    in_ready_d  = 1'b1;
                    out_valid_d = 1'b0;
                end
            end
            default: state_d = FILL;
        endcase
    end

    for (genvar i = 0; i < N; i++) begin : g_lane
        logic [1:0] lane_q;

        and_ary_lane_reg u_lane (
            .clk    (clk),
            .rst    (rst),
            .load   (load_c && (cnt_q == CNT_W'(i))),
            .preset (preset_c),
            .d      ({bus.in_a, bus.in_b}),
            .q      (lane_q)
        );

        assign a_vec_q[i] = lane_q[1];
        assign b_vec_q[i] = lane_q[0];
    end

    assign bus.in_ready  = in_ready_q;
    assign bus.out_valid = out_valid_q;
    assign bus.a_vec     = a_vec_q;
    assign bus.b_vec     = b_vec_q;
    assign bus.word_len  = word_len_q;

endmodule

// File: tb/tb_and_ary_operand_loader.sv
// Directed bench for the AND-reduction operand loader.
module tb_and_ary_operand_loader;

    logic clk;
    logic rst;
    int   checks;
    int   errors;

    and_ary_operand_loader_if #(.N(8), .CNT_W(3)) bus ();

    and_ary_operand_loader #(.N(8), .CNT_W(3)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic beat(input logic a, input logic b, input logic last);
        bus.in_valid = 1'b1;
        bus.in_a     = a;
        bus.in_b     = b;
        bus.in_last  = last;
        step();
        bus.in_valid = 1'b0;
        bus.in_a     = ~a;
        bus.in_b     = ~b;
        bus.in_last  = 1'b1;
    endtask

    task automatic drain();
        bus.out_ready = 1'b1;
        step();
        bus.out_ready = 1'b0;
    endtask

    task automatic chk_word(input string tag, input logic [7:0] a, input logic [7:0] b,
                            input logic [3:0] len);
        chk({tag, "_out_valid"}, 32'(bus.out_valid), 32'd1);
        chk({tag, "_in_ready"},  32'(bus.in_ready),  32'd0);
        chk({tag, "_a_vec"},     32'(bus.a_vec),     32'(a));
        chk({tag, "_b_vec"},     32'(bus.b_vec),     32'(b));
        chk({tag, "_word_len"},  32'(bus.word_len),  32'(len));
    endtask

    task automatic chk_idle(input string tag);
        chk({tag, "_out_valid"}, 32'(bus.out_valid), 32'd0);
        chk({tag, "_in_ready"},  32'(bus.in_ready),  32'd1);
        chk({tag, "_a_vec"},     32'(bus.a_vec),     32'hFF);
        chk({tag, "_b_vec"},     32'(bus.b_vec),     32'hFF);
    endtask

    initial begin
        logic [7:0] pa;
        logic [7:0] pb;
        checks        = 0;
        errors        = 0;
        rst           = 1'b1;
        bus.in_valid  = 1'b0;
        bus.in_a      = 1'b0;
        bus.in_b      = 1'b0;
        bus.in_last   = 1'b0;
        bus.out_ready = 1'b0;
        repeat (3) step();
        rst = 1'b0;
        step();
        chk_idle("reset");
        chk("reset_word_len", 32'(bus.word_len), 32'd0);

        // Full word of ones, in_last on lane 7.
        for (int i = 0; i < 7; i++) beat(1'b1, 1'b1, 1'b0);
        chk("full_pre_last_out_valid", 32'(bus.out_valid), 32'd0);
        beat(1'b1, 1'b1, 1'b1);
        chk_word("full", 8'hFF, 8'hFF, 4'd8);
        drain();
        chk_idle("full_drain");

        // Full word without in_last, distinct lane pattern.
        pa = 8'hA5;
        pb = 8'h3C;
        for (int i = 0; i < 8; i++) beat(pa[i], pb[i], 1'b0);
        chk_word("implicit", 8'hA5, 8'h3C, 4'd8);
        drain();

        // Short word, then backpressure.
        beat(1'b1, 1'b1, 1'b0);
        beat(1'b1, 1'b0, 1'b0);
        beat(1'b1, 1'b1, 1'b1);
        chk_word("short", 8'hFF, 8'hFD, 4'd3);
        bus.in_valid = 1'b1;
        bus.in_a     = 1'b0;
        bus.in_b     = 1'b0;
        bus.in_last  = 1'b0;
        for (int i = 0; i < 10; i++) begin
            step();
            chk("bp_in_ready",  32'(bus.in_ready),  32'd0);
            chk("bp_out_valid", 32'(bus.out_valid), 32'd1);
            chk("bp_b_vec",     32'(bus.b_vec),     32'hFD);
        end
        bus.in_valid = 1'b0;
        chk_word("bp_end", 8'hFF, 8'hFD, 4'd3);
        drain();
        chk_idle("bp_drain");

        // Bubbles: two idle cycles after each valid beat.
        pa = 8'h69;
        pb = 8'hC3;
        for (int i = 0; i < 8; i++) begin
            beat(pa[i], pb[i], (i == 7) ? 1'b1 : 1'b0);
            if (i < 7) begin
                step();
                step();
            end
            if (i == 3) chk("bubble_mid_out_valid", 32'(bus.out_valid), 32'd0);
        end
        chk_word("bubble", 8'h69, 8'hC3, 4'd8);
        drain();

        // Async reset mid-word, asserted between edges.
        for (int i = 0; i < 4; i++) beat(1'b0, 1'b0, 1'b0);
        #3;
        rst = 1'b1;
        #1;
        chk_idle("async_rst");
        chk("async_rst_word_len", 32'(bus.word_len), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        step();
        beat(1'b0, 1'b1, 1'b0);
        beat(1'b1, 1'b0, 1'b1);
        chk_word("post_rst", 8'hFE, 8'hFD, 4'd2);
        drain();

        // Back-to-back single-beat words with out_ready held high.
        bus.out_ready = 1'b1;
        bus.in_valid  = 1'b1;
        bus.in_a      = 1'b0;
        bus.in_b      = 1'b1;
        bus.in_last   = 1'b1;
        step();
        chk_word("b2b_w0", 8'hFE, 8'hFF, 4'd1);
        step();
        chk_idle("b2b_gap");
        step();
        chk_word("b2b_w1", 8'hFE, 8'hFF, 4'd1);
        bus.in_valid = 1'b0;
        step();
        chk_idle("b2b_end");
        bus.out_ready = 1'b0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
